// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational full-adder cell: two half adders plus an OR of their carries.
module serial_fa_cell (
  output logic S,
  output logic C,
  input  logic x,
  input  logic y,
  input  logic z
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a(x),
    .b(y),
    .s(s0),
    .c(c0)
  );

  half_adder u_ha1 (
    .a(s0),
    .b(z),
    .s(S),
    .c(c1)
  );

  assign C = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one bit pair per cycle, LSB first, through
// a single full-adder cell with the carry held in a flop between bits.
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             msb_cin_q;
  logic             fa_s, fa_c;

  serial_fa_cell u_fa (
    .S(fa_s),
    .C(fa_c),
    .x(a_q[0]),
    .y(b_q[0]),
    .z(carry_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            sum     <= '0;
          end
        end
        RUN: begin
          sum     <= {fa_s, sum[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            // carry_q is the carry into the MSB on this final bit
            msb_cin_q <= carry_q;
            state     <= DONE;
            done      <= 1'b1;
            cout      <= fa_c;
            ovf       <= carry_q ^ fa_c;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic unused_msb_cin;
  assign unused_msb_cin = msb_cin_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed-vector bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one operation, scramble inputs afterwards, check latency and results.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic tc, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int n;
    int busy_n;
    @(negedge clk);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tb; sub = ~ts; cin = ~tc;
    check_val({tag, "_busy_on"}, 32'(busy), 32'd1);
    n = 0;
    busy_n = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
    end
    check_val({tag, "_latency"}, 32'(n), 32'(W));
    check_val({tag, "_sum"}, 32'(sum), 32'(es));
    check_val({tag, "_cout"}, 32'(cout), 32'(ec));
    check_val({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check_val({tag, "_busy_cycles"}, 32'(busy_n), 32'(W + 1));
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
    check_val({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int dones;
    int last;

    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_sum", 32'(sum), 32'd0);
    check_val("rst_cout", 32'(cout), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("addff01c", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    run_op("sub1020", 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    run_op("sub8001", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start held high with operands changing while busy: exactly one result.
    @(negedge clk);
    a = 8'h01; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int i = 1; i <= W + 1; i++) begin
      a = 8'(i * 37); b = 8'(i * 91);
      @(posedge clk); #1;
      if (done) begin
        dones++;
        check_val("hold_sum", 32'(sum), 32'h02);
        check_val("hold_edge", 32'(i), 32'(W));
      end
    end
    check_val("hold_idle_after_done", 32'(busy), 32'd0);
    start = 1'b0;
    check_val("hold_done_count", 32'(dones), 32'd1);
    @(posedge clk); #1;
    check_val("hold_no_requeue", 32'(busy), 32'd0);

    // Reset mid-RUN.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_val("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_sum", 32'(sum), 32'd0);
    check_val("abort_cout", 32'(cout), 32'd0);
    check_val("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add0304", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    // Back-to-back with start held for 30 cycles: a done every W+2 cycles.
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b1; start = 1'b1;
    dones = 0;
    last = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        check_val("b2b_sum", 32'(sum), 32'h47);
        if (last >= 0) check_val("b2b_spacing", 32'(cyc - last), 32'(W + 2));
        last = cyc;
      end
    end
    start = 1'b0;
    check_val("b2b_done_count", 32'(dones), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
